// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan driver.
//   SEG_OFF : unlit segment pattern (before output polarity is applied)
//   GLYPH   : hex glyph table, bits {a,b,c,d,e,f,g}, 1 = lit, a = bit 6
//   clog2   : register width for a counter holding 0..n-1 (minimum 1)
package sevenseg_pkg;

    localparam logic [6:0] SEG_OFF = 7'b000_0000;

    localparam logic [6:0] GLYPH [16] = '{
        7'b111_1110, 7'b011_0000, 7'b110_1101, 7'b111_1001,
        7'b011_0011, 7'b101_1011, 7'b101_1111, 7'b111_0000,
        7'b111_1111, 7'b111_1011, 7'b111_0111, 7'b001_1111,
        7'b100_1110, 7'b011_1101, 7'b100_1111, 7'b100_0111
    };

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to seven-segment glyph decoder.
//   i_nib   : hex digit 0..F
//   o_glyph : {a,b,c,d,e,f,g}, 1 = lit (active-high, polarity applied by caller)
module seg_hex_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_glyph
);

    always_comb begin
        o_glyph = GLYPH[i_nib];
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed driver for NUM_DIGITS seven-segment digits on one bus.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : scan enable; low blanks the display and freezes scanning
//   value       : packed hex nibbles, digit 0 in value[3:0]
//   dp_in       : per-digit decimal point request
//   blank_in    : per-digit forced blank
//   seg, dp     : registered segment bus {a..g} and decimal point
//   digit_sel   : registered one-hot digit enable
//   frame_done  : one-cycle pulse when the last digit's dwell ends
// Outputs are computed from the current prescaler/index and appear one
// cycle later; the prescaler = 0 cycle therefore loads the new digit's
// segments with all selects off, giving the dead cycle ahead of the select.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1,
    parameter bit          LZ_BLANK       = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int unsigned   IW       = clog2(NUM_DIGITS);
    localparam int unsigned   PW       = clog2(SCAN_DIV);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0]             r_presc;
    logic [IW-1:0]             r_idx;
    logic [4*NUM_DIGITS-1:0]   r_val;
    logic [NUM_DIGITS-1:0]     r_dpm;
    logic [NUM_DIGITS-1:0]     r_blk;
    logic [6:0]                r_seg;
    logic                      r_dp;
    logic [NUM_DIGITS-1:0]     r_sel;
    logic                      r_fd;

    logic                      w_snap;
    logic [4*NUM_DIGITS-1:0]   w_val;
    logic [NUM_DIGITS-1:0]     w_dpm;
    logic [NUM_DIGITS-1:0]     w_blk;
    logic [NUM_DIGITS-1:0]     w_lz;
    logic [NUM_DIGITS-1:0]     w_onehot;
    logic [3:0]                w_nib;
    logic                      w_sel_dp;
    logic                      w_sel_blank;
    logic                      w_sel_lz;
    logic [6:0]                w_glyph;
    logic [6:0]                w_seg_lit;
    logic                      w_dp_lit;
    logic [NUM_DIGITS-1:0]     w_sel_lit;

    // Frame-start snapshot; the digit-0 segments loaded on this same edge
    // must already see the freshly captured inputs, so bypass the shadow.
    assign w_snap = enable && (r_idx == '0) && (r_presc == '0);
    assign w_val  = w_snap ? value    : r_val;
    assign w_dpm  = w_snap ? dp_in    : r_dpm;
    assign w_blk  = w_snap ? blank_in : r_blk;

    always_comb begin
        w_nib       = '0;
        w_sel_dp    = 1'b0;
        w_sel_blank = 1'b0;
        w_sel_lz    = 1'b0;
        w_onehot    = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_nib       = w_val[4*i +: 4];
                w_sel_dp    = w_dpm[i];
                w_sel_blank = w_blk[i];
                w_sel_lz    = w_lz[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    // Digit i is a leading zero when it and every digit above it are zero.
    // Digit 0 is never suppressed.
    always_comb begin
        logic above;
        above = 1'b1;
        w_lz  = '0;
        for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
            if (w_val[4*(NUM_DIGITS-1-k) +: 4] != 4'h0) above = 1'b0;
            w_lz[NUM_DIGITS-1-k] = above;
        end
    end

    seg_hex_decode u_dec (
        .i_nib   (w_nib),
        .o_glyph (w_glyph)
    );

    assign w_seg_lit = (w_sel_blank || (LZ_BLANK && w_sel_lz)) ? SEG_OFF : w_glyph;
    assign w_dp_lit  = !w_sel_blank && w_sel_dp;
    assign w_sel_lit = (r_presc == '0) ? '0 : w_onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_val   <= '0;
            r_dpm   <= '0;
            r_blk   <= '0;
            r_seg   <= {7{SEG_ACTIVE_LOW}};
            r_dp    <= SEG_ACTIVE_LOW;
            r_sel   <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
            r_fd    <= 1'b0;
        end else if (!enable) begin
            r_seg   <= {7{SEG_ACTIVE_LOW}};
            r_dp    <= SEG_ACTIVE_LOW;
            r_sel   <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
            r_fd    <= 1'b0;
        end else begin
            if (w_snap) begin
                r_val <= value;
                r_dpm <= dp_in;
                r_blk <= blank_in;
            end
            r_seg <= w_seg_lit ^ {7{SEG_ACTIVE_LOW}};
            r_dp  <= w_dp_lit ^ SEG_ACTIVE_LOW;
            r_sel <= w_sel_lit ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
            r_fd  <= (r_presc == PRE_LAST) && (r_idx == IDX_LAST);
            if (r_presc == PRE_LAST) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign digit_sel  = r_sel;
    assign frame_done = r_fd;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench: two instances (leading-zero suppression on / off) share
// the stimulus; each frame is 16 cycles (4 digits x dwell 4).
module tb_sevenseg_scan;

    typedef struct {
        logic [15:0]     val;
        logic [3:0]      dpi;
        logic [3:0]      blk;
        logic [3:0][6:0] seg_lz;    // expected pin level per digit, LZ on
        logic [3:0][6:0] seg_nolz;  // expected pin level per digit, LZ off
        logic [3:0]      dp_exp;    // expected dp pin per digit
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;

    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [3:0]  sel0, sel1;
    logic        fd0, fd1;

    int n_vec = 0;
    int n_bad = 0;

    vec_t vecs [6];
    vec_t v11, v22;

    always #5 clk = ~clk;

    sevenseg_scan #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)
    ) u_lz (
        .clk(clk), .rst_n(rst_n), .enable(enable), .value(value),
        .dp_in(dp_in), .blank_in(blank_in), .seg(seg0), .dp(dp0),
        .digit_sel(sel0), .frame_done(fd0)
    );

    sevenseg_scan #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0)
    ) u_nolz (
        .clk(clk), .rst_n(rst_n), .enable(enable), .value(value),
        .dp_in(dp_in), .blank_in(blank_in), .seg(seg1), .dp(dp1),
        .digit_sel(sel1), .frame_done(fd1)
    );

    task automatic chk(input string name, input int k,
                       input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s k=%0d got %h want %h", name, k, act, exp);
        end
    endtask

    task automatic check_inactive(input int k);
        chk("idle_sel_lz",   k, 16'(sel0), 16'h000F);
        chk("idle_seg_lz",   k, 16'(seg0), 16'h007F);
        chk("idle_dp_lz",    k, 16'(dp0),  16'h0001);
        chk("idle_fd_lz",    k, 16'(fd0),  16'h0000);
        chk("idle_sel_nolz", k, 16'(sel1), 16'h000F);
        chk("idle_seg_nolz", k, 16'(seg1), 16'h007F);
    endtask

    task automatic check_sample(input vec_t v, input int k);
        int d;
        int ph;
        logic [3:0] esel;
        d  = (k - 1) / 4;
        ph = (k - 1) % 4;
        esel = (ph == 0) ? 4'hF : ~(4'b0001 << d);
        chk("sel_lz",   k, 16'(sel0), 16'(esel));
        chk("sel_nolz", k, 16'(sel1), 16'(esel));
        chk("seg_lz",   k, 16'(seg0), 16'(v.seg_lz[d]));
        chk("seg_nolz", k, 16'(seg1), 16'(v.seg_nolz[d]));
        chk("dp_lz",    k, 16'(dp0),  16'(v.dp_exp[d]));
        chk("dp_nolz",  k, 16'(dp1),  16'(v.dp_exp[d]));
        chk("fd_lz",    k, 16'(fd0),  16'(k == 16));
        chk("fd_nolz",  k, 16'(fd1),  16'(k == 16));
    endtask

    task automatic apply(input vec_t v);
        value    = v.val;
        dp_in    = v.dpi;
        blank_in = v.blk;
    endtask

    // Call at a negedge just before the snapshot edge.
    task automatic run_frame(input vec_t v, input int chg_k,
                             input logic [15:0] chg_val, input int pause_k);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check_sample(v, k);
            if (k == chg_k) value = chg_val;
            if (k == pause_k) begin
                enable = 1'b0;
                for (int p = 0; p < 10; p++) begin
                    @(negedge clk);
                    check_inactive(100 + p);
                end
                enable = 1'b1;
            end
        end
    endtask

    initial begin
        vecs[0] = '{val: 16'h12AF, dpi: 4'b0000, blk: 4'b0000,
                    seg_lz:   {7'h4F, 7'h12, 7'h08, 7'h38},
                    seg_nolz: {7'h4F, 7'h12, 7'h08, 7'h38}, dp_exp: 4'b1111};
        vecs[1] = '{val: 16'h0070, dpi: 4'b0000, blk: 4'b0000,
                    seg_lz:   {7'h7F, 7'h7F, 7'h0F, 7'h01},
                    seg_nolz: {7'h01, 7'h01, 7'h0F, 7'h01}, dp_exp: 4'b1111};
        vecs[2] = '{val: 16'h0000, dpi: 4'b0100, blk: 4'b0000,
                    seg_lz:   {7'h7F, 7'h7F, 7'h7F, 7'h01},
                    seg_nolz: {7'h01, 7'h01, 7'h01, 7'h01}, dp_exp: 4'b1011};
        vecs[3] = '{val: 16'h8E3D, dpi: 4'b1001, blk: 4'b1000,
                    seg_lz:   {7'h7F, 7'h30, 7'h06, 7'h42},
                    seg_nolz: {7'h7F, 7'h30, 7'h06, 7'h42}, dp_exp: 4'b1110};
        vecs[4] = '{val: 16'h0005, dpi: 4'b0001, blk: 4'b0001,
                    seg_lz:   {7'h7F, 7'h7F, 7'h7F, 7'h7F},
                    seg_nolz: {7'h01, 7'h01, 7'h01, 7'h7F}, dp_exp: 4'b1111};
        vecs[5] = '{val: 16'h0900, dpi: 4'b0000, blk: 4'b0000,
                    seg_lz:   {7'h7F, 7'h04, 7'h01, 7'h01},
                    seg_nolz: {7'h01, 7'h04, 7'h01, 7'h01}, dp_exp: 4'b1111};
        v11 = '{val: 16'h1111, dpi: 4'b0000, blk: 4'b0000,
                seg_lz:   {7'h4F, 7'h4F, 7'h4F, 7'h4F},
                seg_nolz: {7'h4F, 7'h4F, 7'h4F, 7'h4F}, dp_exp: 4'b1111};
        v22 = '{val: 16'h2222, dpi: 4'b0000, blk: 4'b0000,
                seg_lz:   {7'h12, 7'h12, 7'h12, 7'h12},
                seg_nolz: {7'h12, 7'h12, 7'h12, 7'h12}, dp_exp: 4'b1111};

        repeat (3) @(negedge clk);
        check_inactive(0);

        apply(vecs[0]);
        rst_n  = 1'b1;
        enable = 1'b1;
        run_frame(vecs[0], 0, 16'h0, 0);
        for (int i = 1; i < 6; i++) begin
            apply(vecs[i]);
            run_frame(vecs[i], 0, 16'h0, 0);
        end

        // Mid-frame input change during digit 1's dwell.
        apply(v11);
        run_frame(v11, 6, 16'h2222, 0);
        run_frame(v22, 0, 16'h0, 0);

        // Enable dropped for 10 cycles during digit 1's dwell.
        apply(vecs[0]);
        run_frame(vecs[0], 0, 16'h0, 6);

        // Reset pulsed in the middle of digit 1's dwell.
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check_sample(vecs[0], k);
        end
        #2 rst_n = 1'b0;
        #1 check_inactive(200);
        apply(vecs[1]);
        @(negedge clk);
        check_inactive(201);
        rst_n = 1'b1;
        run_frame(vecs[1], 0, 16'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
- Parametrised, time-multiplexed driver for NUM_DIGITS common-anode/cathode seven-segment digits sharing one segment bus.
- Takes a packed hex word plus per-digit decimal-point and blank masks, and snapshots them once per scan frame so the display never tears.
- Rotates a one-hot digit select with a programmable dwell and a one-cycle dead time between digits.
- Sits between the datapath (counters, results) and the board display pins; it replaces the single-digit combinational decoder.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (legal range 2..8).
- SCAN_DIV, 50000, clock cycles each digit is selected, including the dead cycle (minimum 2).
- SEG_ACTIVE_LOW, 1, 1 = segment/dp pins are driven 0 to light.
- DIG_ACTIVE_LOW, 1, 1 = digit_sel pins are driven 0 to enable.
- LZ_BLANK, 1, 1 = leading-zero suppression is enabled.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable; low blanks the display.
- value  in  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i], digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- blank_in  in  NUM_DIGITS  force digit i dark.
- seg  out  7  segments {a,b,c,d,e,f,g}, with a = bit 6.
- dp  out  1  decimal point of the selected digit.
- digit_sel  out  NUM_DIGITS  one-hot digit enable (polarity per DIG_ACTIVE_LOW).
- frame_done  out  1  one-cycle pulse when the last digit's dwell ends.

Behaviour:
- Reset state (async, on rst_n low):
  - prescaler = 0, index = 0, shadow registers = 0, frame_done = 0.
  - seg, dp and digit_sel are driven to their inactive levels.
- All outputs are registered.
- Prescaler:
  - Counts 0..SCAN_DIV-1 while enable = 1.
  - On the terminal count it wraps to 0 and index advances, wrapping from NUM_DIGITS-1 to 0.
- frame_done:
  - Asserts for exactly one cycle on the cycle index wraps to 0.
- Snapshot:
  - value, dp_in and blank_in are captured into shadow registers when index is 0 and prescaler is 0, i.e. at frame start and on the first enabled cycle after reset.
  - Input changes mid-frame are not visible until the next frame.
- Dead time:
  - While prescaler = 0, digit_sel is all inactive.
  - For prescaler 1..SCAN_DIV-1, digit_sel selects index only.
  - seg and dp for the new index are updated on the prescaler = 0 cycle, so they are stable before the select asserts.
- Decode: standard hex glyphs, abcdefg with 1 = lit before polarity:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- Blanking precedence, highest first:
  1. enable = 0: all segments, dp and digit_sel inactive; prescaler and index hold their values.
  2. shadow blank_in[i] = 1: seg and dp are off, but the digit is still scanned.
  3. LZ_BLANK = 1 and digit i lies above the most significant nonzero shadow nibble: seg is off, and dp is still honoured. Digit 0 is never zero-suppressed.
- Polarity: seg and dp are XORed with SEG_ACTIVE_LOW, digit_sel with DIG_ACTIVE_LOW, at the output register input.
- Re-enable: when enable rises, scanning resumes from the held index/prescaler.
- Reset mid-frame: outputs go inactive immediately (asynchronously). After release, scanning restarts at digit 0 with a fresh snapshot.

Decomposition:
- Package sevenseg_pkg holds:
  - SEG_OFF constant;
  - the 16-entry glyph table as a localparam array;
  - the function clog2 for the index width.
- Sub-module seg_hex_decode: combinational nibble -> 7-bit glyph, instantiated once on the muxed shadow nibble.
- Prescaler, index, snapshot, blanking and output registers stay in sevenseg_scan.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, active-low both, LZ_BLANK=1 unless stated):
- Reset then value=16'h12AF, enable=1:
  - digit_sel cycles 1110, 1101, 1011, 0111, each active for 3 cycles with 1 dead cycle of 1111 before it.
  - seg = ~F, ~A, ~2, ~1 in that order.
  - frame_done pulses once every 16 cycles.
- value=16'h0070:
  - digits 3 and 2 show seg=7'h7F (off); digit 1 shows ~7, digit 0 shows ~0.
  - With LZ_BLANK=0, digits 3 and 2 show ~0.
- value=16'h0000, dp_in=4'b0100:
  - only digit 0 shows ~0; digit 2 has seg off and dp=0 (lit).
- Change value from 16'h1111 to 16'h2222 during digit 1's dwell:
  - digits 1..3 keep showing ~1 until the frame ends; the next frame shows ~2 on all digits.
- enable=0 for 10 cycles mid-dwell:
  - digit_sel=1111 and seg=7'h7F throughout.
  - After enable=1 the same digit resumes with its remaining dwell.
- rst_n pulsed low mid-frame:
  - outputs go inactive in the same cycle.
  - After release, the first selected digit is digit 0 with a freshly captured value; frame_done=0 until the next wrap.
